// File: rtl/dmem_request_arbiter_pkg.sv
// Shared types and constants for the data-memory request arbiter.
// Data width and load-tag width are fixed here because the request struct
// depends on them.
package dmem_request_arbiter_pkg;

  localparam int XLEN           = 32;
  localparam int LQ_INDEX_WIDTH = 3;
  localparam int BYTE_EN_WIDTH  = XLEN / 8;

  // Byte-enable pattern used for every read.
  localparam logic [BYTE_EN_WIDTH-1:0] FULL_BYTE_EN = '1;

  typedef logic [LQ_INDEX_WIDTH-1:0] lq_tag_t;

  // One data-memory request as held in the output register.
  typedef struct packed {
    logic                     write;
    logic [XLEN-1:0]          address;
    logic [XLEN-1:0]          data;
    logic [BYTE_EN_WIDTH-1:0] byte_en;
  } mem_req_t;

  // One outstanding read: who asked for it and whether a flush killed it.
  typedef struct packed {
    lq_tag_t tag;
    logic    killed;
  } pending_entry_t;

endpackage

// File: rtl/dmem_request_arbiter_pending_tag_fifo.sv
// In-order FIFO of outstanding read tags. Each entry carries a killed bit
// that kill_all sets on every entry, including one written in the same cycle.
module pending_tag_fifo
  import dmem_request_arbiter_pkg::*;
#(
  parameter int PEND_LOG2 = 2
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    push,
  input  lq_tag_t push_tag,
  input  logic    pop,
  input  logic    kill_all,
  output logic    full,
  output logic    empty,
  output lq_tag_t head_tag,
  output logic    head_killed
);

  localparam int DEPTH = 1 << PEND_LOG2;
  localparam logic [PEND_LOG2:0] DEPTH_COUNT = (PEND_LOG2 + 1)'(DEPTH);

  pending_entry_t       entries [DEPTH];
  logic [PEND_LOG2-1:0] wr_ptr;
  logic [PEND_LOG2-1:0] rd_ptr;
  logic [PEND_LOG2:0]   count;
  logic                 do_push;
  logic                 do_pop;

  // Full and empty come from the registered count only, so a pop in this
  // cycle never opens a slot for a push in the same cycle.
  assign full    = (count == DEPTH_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_tag    = entries[rd_ptr].tag;
  assign head_killed = entries[rd_ptr].killed;

  // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: every sequential assignment is non-blocking so all registers
    // update together from the pre-edge values, independent of block order.
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: write on push, mark everything killed on kill_all.
  always_ff @(posedge clock) begin
    // NOTE: storage has no reset; an entry is only read while count says it
    // is valid, and a push always overwrites both fields before that.
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && (wr_ptr == PEND_LOG2'(i))) begin
        entries[i].tag    <= push_tag;
        entries[i].killed <= kill_all;
      end else if (kill_all) begin
        // Killing stale slots is harmless: they are rewritten on push.
        entries[i].killed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_request_arbiter.sv
// Merges committed stores and load reads onto one data-memory request port
// through a single output register, tracks outstanding reads in order, and
// returns read data to the load unit unless a flush killed the load.
module dmem_request_arbiter
  import dmem_request_arbiter_pkg::*;
#(
  parameter int PEND_LOG2    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,

  input  logic                      store_request_valid,
  output logic                      store_request_ready,
  input  logic [XLEN-1:0]           store_request_address,
  input  logic [XLEN-1:0]           store_request_value,
  input  logic [BYTE_EN_WIDTH-1:0]  store_request_byte_en,

  input  logic                      load_request_valid,
  output logic                      load_request_ready,
  input  logic [XLEN-1:0]           load_request_address,
  input  logic [LQ_INDEX_WIDTH-1:0] load_request_tag,

  output logic                      load_response_valid,
  output logic [LQ_INDEX_WIDTH-1:0] load_response_tag,
  output logic [XLEN-1:0]           load_response_data,

  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_write,
  output logic [XLEN-1:0]           mem_req_address,
  output logic [XLEN-1:0]           mem_req_data,
  output logic [BYTE_EN_WIDTH-1:0]  mem_req_byte_en,

  input  logic                      mem_resp_valid,
  input  logic [XLEN-1:0]           mem_resp_data
);

  localparam int STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);

  mem_req_t                mem_req_q;
  logic                    mem_req_valid_q;
  logic [STARVE_WIDTH-1:0] starve_cnt;

  logic    out_free;
  logic    load_ok;
  logic    store_grant;
  logic    load_grant;
  logic    fifo_full;
  logic    fifo_empty;
  lq_tag_t fifo_head_tag;
  logic    fifo_head_killed;
  logic    resp_deliver;

  assign mem_req_valid   = mem_req_valid_q;
  assign mem_req_write   = mem_req_q.write;
  assign mem_req_address = mem_req_q.address;
  assign mem_req_data    = mem_req_q.data;
  assign mem_req_byte_en = mem_req_q.byte_en;

  assign store_request_ready = store_grant;
  assign load_request_ready  = load_grant;

  // Grant selection: stores win unless a load is eligible, except that a
  // store that has lost STARVE_LIMIT times in a row is forced through.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    out_free    = 1'b0;
    load_ok     = 1'b0;
    store_grant = 1'b0;
    load_grant  = 1'b0;
    if (reset) begin
      out_free = !mem_req_valid_q || mem_req_ready;
      load_ok  = load_request_valid && !flush && !fifo_full;
      if (out_free) begin
        if (store_request_valid && (!load_ok || (starve_cnt == STARVE_MAX))) begin
          store_grant = 1'b1;
        end else if (load_ok) begin
          load_grant = 1'b1;
        end
      end
    end
  end

  // Consecutive-loss counter for a waiting store, saturating at the limit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!store_request_valid || store_grant) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Output register: loads on a grant, empties on acceptance, otherwise holds
  // its payload so it stays stable while memory back-pressures.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_req_valid_q <= 1'b0;
      mem_req_q       <= '0;
    end else if (store_grant) begin
      mem_req_valid_q   <= 1'b1;
      mem_req_q.write   <= 1'b1;
      mem_req_q.address <= store_request_address;
      mem_req_q.data    <= store_request_value;
      mem_req_q.byte_en <= store_request_byte_en;
    end else if (load_grant) begin
      mem_req_valid_q   <= 1'b1;
      mem_req_q.write   <= 1'b0;
      mem_req_q.address <= load_request_address;
      mem_req_q.data    <= '0;
      mem_req_q.byte_en <= FULL_BYTE_EN;
    end else if (mem_req_ready) begin
      mem_req_valid_q <= 1'b0;
    end
  end

  pending_tag_fifo #(
    .PEND_LOG2 (PEND_LOG2)
  ) u_pending_tag_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (load_grant),
    .push_tag    (load_request_tag),
    .pop         (mem_resp_valid),
    .kill_all    (flush),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head_tag    (fifo_head_tag),
    .head_killed (fifo_head_killed)
  );

  // A response is forwarded only if it matches a live, unkilled load and no
  // flush is killing it in this very cycle.
  assign resp_deliver = mem_resp_valid && !fifo_empty && !fifo_head_killed && !flush;

  // Registered response path: one-cycle pulse with the head tag and data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_response_valid <= 1'b0;
      load_response_tag   <= '0;
      load_response_data  <= '0;
    end else begin
      load_response_valid <= resp_deliver;
      if (resp_deliver) begin
        load_response_tag  <= fifo_head_tag;
        load_response_data <= mem_resp_data;
      end
    end
  end

  // Memory must never return read data with no read outstanding.
  resp_without_pending_read: assert property (
    @(posedge clock) disable iff (!reset) !(mem_resp_valid && fifo_empty)
  );

endmodule

// File: tb/tb_dmem_request_arbiter.sv
// Directed bench for dmem_request_arbiter: reset, store path, back-pressure,
// load round trip, store starvation limit, tag FIFO full/order, and flush.
module tb_dmem_request_arbiter;
  import dmem_request_arbiter_pkg::*;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      flush;
  logic                      store_request_valid;
  logic                      store_request_ready;
  logic [XLEN-1:0]           store_request_address;
  logic [XLEN-1:0]           store_request_value;
  logic [BYTE_EN_WIDTH-1:0]  store_request_byte_en;
  logic                      load_request_valid;
  logic                      load_request_ready;
  logic [XLEN-1:0]           load_request_address;
  logic [LQ_INDEX_WIDTH-1:0] load_request_tag;
  logic                      load_response_valid;
  logic [LQ_INDEX_WIDTH-1:0] load_response_tag;
  logic [XLEN-1:0]           load_response_data;
  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic                      mem_req_write;
  logic [XLEN-1:0]           mem_req_address;
  logic [XLEN-1:0]           mem_req_data;
  logic [BYTE_EN_WIDTH-1:0]  mem_req_byte_en;
  logic                      mem_resp_valid;
  logic [XLEN-1:0]           mem_resp_data;

  int checks   = 0;
  int failures = 0;
  int lost;
  bit granted;

  always #5 clock = ~clock;

  dmem_request_arbiter #(
    .PEND_LOG2    (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .flush                 (flush),
    .store_request_valid   (store_request_valid),
    .store_request_ready   (store_request_ready),
    .store_request_address (store_request_address),
    .store_request_value   (store_request_value),
    .store_request_byte_en (store_request_byte_en),
    .load_request_valid    (load_request_valid),
    .load_request_ready    (load_request_ready),
    .load_request_address  (load_request_address),
    .load_request_tag      (load_request_tag),
    .load_response_valid   (load_response_valid),
    .load_response_tag     (load_response_tag),
    .load_response_data    (load_response_data),
    .mem_req_valid         (mem_req_valid),
    .mem_req_ready         (mem_req_ready),
    .mem_req_write         (mem_req_write),
    .mem_req_address       (mem_req_address),
    .mem_req_data          (mem_req_data),
    .mem_req_byte_en       (mem_req_byte_en),
    .mem_resp_valid        (mem_resp_valid),
    .mem_resp_data         (mem_resp_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; registered outputs are then stable.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Let combinational outputs settle after changing inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                 = 1'b0;
    flush                 = 1'b0;
    store_request_valid   = 1'b0;
    store_request_address = '0;
    store_request_value   = '0;
    store_request_byte_en = '0;
    load_request_valid    = 1'b0;
    load_request_address  = '0;
    load_request_tag      = '0;
    mem_req_ready         = 1'b0;
    mem_resp_valid        = 1'b0;
    mem_resp_data         = '0;

    // Reset held for five cycles: every output must be zero.
    repeat (5) @(posedge clock);
    #1;
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_req_write", mem_req_write, 0);
    check("rst_mem_req_address", mem_req_address, 0);
    check("rst_mem_req_data", mem_req_data, 0);
    check("rst_mem_req_byte_en", mem_req_byte_en, 0);
    check("rst_store_ready", store_request_ready, 0);
    check("rst_load_ready", load_request_ready, 0);
    check("rst_resp_valid", load_response_valid, 0);
    check("rst_resp_tag", load_response_tag, 0);
    check("rst_resp_data", load_response_data, 0);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("idle_mem_req_valid", mem_req_valid, 0);
      tick();
    end

    // Single store, memory always ready.
    mem_req_ready         = 1'b1;
    store_request_valid   = 1'b1;
    store_request_address = 32'd10001;
    store_request_value   = 32'd1001;
    store_request_byte_en = 4'hF;
    settle();
    check("st_ready", store_request_ready, 1);
    check("st_load_ready", load_request_ready, 0);
    tick();
    store_request_valid = 1'b0;
    settle();
    check("st_ready_drop", store_request_ready, 0);
    check("st_mem_valid", mem_req_valid, 1);
    check("st_mem_write", mem_req_write, 1);
    check("st_mem_address", mem_req_address, 32'd10001);
    check("st_mem_data", mem_req_data, 32'd1001);
    check("st_mem_byte_en", mem_req_byte_en, 4'hF);
    tick();
    check("st_mem_valid_clear", mem_req_valid, 0);

    // Back-pressure: payload holds, second store waits until acceptance.
    mem_req_ready         = 1'b0;
    store_request_valid   = 1'b1;
    store_request_address = 32'h500;
    store_request_value   = 32'h55AA;
    store_request_byte_en = 4'h3;
    settle();
    check("bp_first_ready", store_request_ready, 1);
    tick();
    store_request_address = 32'h600;
    store_request_value   = 32'h66;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("bp_second_blocked", store_request_ready, 0);
      check("bp_hold_valid", mem_req_valid, 1);
      check("bp_hold_address", mem_req_address, 32'h500);
      check("bp_hold_data", mem_req_data, 32'h55AA);
      check("bp_hold_byte_en", mem_req_byte_en, 4'h3);
      tick();
    end
    mem_req_ready = 1'b1;
    settle();
    check("bp_second_ready", store_request_ready, 1);
    tick();
    store_request_valid = 1'b0;
    check("bp_second_valid", mem_req_valid, 1);
    check("bp_second_address", mem_req_address, 32'h600);
    check("bp_second_data", mem_req_data, 32'h66);
    tick();
    check("bp_drain", mem_req_valid, 0);

    // Load round trip: tag 5 at 0x40, data returned three cycles later.
    load_request_valid   = 1'b1;
    load_request_tag     = 3'd5;
    load_request_address = 32'h40;
    settle();
    check("ld_ready", load_request_ready, 1);
    tick();
    load_request_valid = 1'b0;
    settle();
    check("ld_mem_valid", mem_req_valid, 1);
    check("ld_mem_write", mem_req_write, 0);
    check("ld_mem_address", mem_req_address, 32'h40);
    check("ld_mem_data", mem_req_data, 0);
    check("ld_mem_byte_en", mem_req_byte_en, 4'hF);
    tick();
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEADBEEF;
    settle();
    check("ld_resp_not_early", load_response_valid, 0);
    tick();
    mem_resp_valid = 1'b0;
    check("ld_resp_valid", load_response_valid, 1);
    check("ld_resp_tag", load_response_tag, 5);
    check("ld_resp_data", load_response_data, 32'hDEADBEEF);
    tick();
    check("ld_resp_pulse", load_response_valid, 0);

    // Starvation: loads always valid, responses keep the FIFO from filling;
    // the store must lose exactly four times and then be forced through.
    store_request_valid   = 1'b1;
    store_request_address = 32'h200;
    store_request_value   = 32'h2222;
    store_request_byte_en = 4'hF;
    load_request_valid    = 1'b1;
    load_request_tag      = 3'd1;
    load_request_address  = 32'h80;
    lost    = 0;
    granted = 1'b0;
    for (int k = 0; k < 10 && !granted; k++) begin
      mem_resp_valid = (k >= 1);
      mem_resp_data  = 32'(k);
      settle();
      if (store_request_ready) granted = 1'b1;
      else                     lost++;
      tick();
    end
    store_request_valid = 1'b0;
    load_request_valid  = 1'b0;
    mem_resp_valid      = 1'b0;
    check("starve_granted", granted, 1);
    check("starve_lost_cycles", lost, 4);
    check("starve_mem_write", mem_req_write, 1);
    check("starve_mem_address", mem_req_address, 32'h200);
    tick();
    tick();

    // Tag FIFO: four loads fill it, the fifth waits past the popping cycle.
    for (int i = 0; i < 4; i++) begin
      load_request_valid   = 1'b1;
      load_request_tag     = 3'(i);
      load_request_address = 32'(32'h100 + 4 * i);
      settle();
      check("fifo_fill_ready", load_request_ready, 1);
      tick();
    end
    load_request_tag     = 3'd4;
    load_request_address = 32'h110;
    settle();
    check("fifo_full_ready", load_request_ready, 0);
    tick();
    settle();
    check("fifo_full_ready_hold", load_request_ready, 0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hA0;
    settle();
    check("fifo_pop_same_cycle", load_request_ready, 0);
    tick();
    mem_resp_valid = 1'b0;
    settle();
    check("fifo_after_pop_ready", load_request_ready, 1);
    check("fifo_resp0_valid", load_response_valid, 1);
    check("fifo_resp0_tag", load_response_tag, 0);
    check("fifo_resp0_data", load_response_data, 32'hA0);
    tick();
    load_request_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'(32'hA0 + i);
      tick();
      check("fifo_resp_valid", load_response_valid, 1);
      check("fifo_resp_tag", load_response_tag, 64'(i));
      check("fifo_resp_data", load_response_data, 64'(32'hA0 + i));
    end
    mem_resp_valid = 1'b0;
    tick();

    // Flush: two loads outstanding, a store parked in the output register.
    load_request_valid   = 1'b1;
    load_request_tag     = 3'd2;
    load_request_address = 32'h20;
    settle();
    check("fl_load2_ready", load_request_ready, 1);
    tick();
    load_request_tag     = 3'd3;
    load_request_address = 32'h24;
    settle();
    check("fl_load3_ready", load_request_ready, 1);
    tick();
    load_request_valid = 1'b0;
    tick();
    mem_req_ready         = 1'b0;
    store_request_valid   = 1'b1;
    store_request_address = 32'h700;
    store_request_value   = 32'h77;
    store_request_byte_en = 4'hF;
    settle();
    check("fl_store_ready", store_request_ready, 1);
    tick();
    store_request_valid  = 1'b0;
    flush                = 1'b1;
    load_request_valid   = 1'b1;
    load_request_tag     = 3'd6;
    load_request_address = 32'h60;
    mem_req_ready        = 1'b1;
    settle();
    check("fl_no_load_grant", load_request_ready, 0);
    check("fl_store_valid", mem_req_valid, 1);
    check("fl_store_write", mem_req_write, 1);
    check("fl_store_address", mem_req_address, 32'h700);
    tick();
    flush              = 1'b0;
    load_request_valid = 1'b0;
    settle();
    check("fl_store_done", mem_req_valid, 0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h11;
    tick();
    check("fl_drop_first", load_response_valid, 0);
    mem_resp_data = 32'h22;
    tick();
    mem_resp_valid = 1'b0;
    check("fl_drop_second", load_response_valid, 0);
    load_request_valid   = 1'b1;
    load_request_tag     = 3'd7;
    load_request_address = 32'h300;
    settle();
    check("fl_load7_ready", load_request_ready, 1);
    tick();
    load_request_valid = 1'b0;
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h77;
    tick();
    mem_resp_valid = 1'b0;
    check("fl_resp7_valid", load_response_valid, 1);
    check("fl_resp7_tag", load_response_tag, 7);
    check("fl_resp7_data", load_response_data, 32'h77);
    tick();
    check("fl_resp7_pulse", load_response_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
